// File: rtl/v810_bus_arb.sv
// v810 bus arbiter: serialises instruction-fetch and data-access requests
// from the execution unit onto one bus-cycle request for the sequencer.
// Data wins ties until D_BURST_MAX consecutive data grants have been given
// while a fetch is waiting; the fetch is then forced through.
module v810_bus_arb #(
    parameter logic [1:0] ST_IFETCH   = 2'b11,
    parameter int         D_BURST_MAX = 4
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    input  logic        IREQ,
    input  logic [31:0] IA,
    output logic        IACK,
    output logic [31:0] ID,
    input  logic        DREQ,
    input  logic [31:0] DA,
    input  logic [31:0] DD_I,
    input  logic [3:0]  DBE,
    input  logic        DWR,
    input  logic        DMRQ,
    input  logic [1:0]  DST,
    output logic        DACK,
    output logic [31:0] DD_O,
    output logic        BREQ,
    output logic [31:0] BA,
    output logic [31:0] BD_O,
    output logic [3:0]  BBE,
    output logic        BWR,
    output logic        BMRQ,
    output logic [1:0]  BST,
    input  logic        BACK,
    input  logic [31:0] BD_I
);

    localparam logic [3:0] BURST_MAX = 4'(D_BURST_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        breq_q, breq_d;
    logic        iack_q, iack_d;
    logic        dack_q, dack_d;
    logic [31:0] id_q, id_d;
    logic [31:0] dd_q, dd_d;
    logic [31:0] ba_q, ba_d;
    logic [31:0] bd_q, bd_d;
    logic [3:0]  bbe_q, bbe_d;
    logic        bwr_q, bwr_d;
    logic        bmrq_q, bmrq_d;
    logic [1:0]  bst_q, bst_d;

    logic        pick_data;

    // Data wins unless a fetch is waiting and the data burst allowance is used up.
    assign pick_data = DREQ && (!IREQ || (cnt_q < BURST_MAX));

    // Next-state, grant latching and completion handling; everything holds when CE=0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        breq_d  = breq_q;
        iack_d  = iack_q;
        dack_d  = dack_q;
        id_d    = id_q;
        dd_d    = dd_q;
        ba_d    = ba_q;
        bd_d    = bd_q;
        bbe_d   = bbe_q;
        bwr_d   = bwr_q;
        bmrq_d  = bmrq_q;
        bst_d   = bst_q;
        if (CE) begin
            unique case (state_q)
                IDLE: begin
                    if (pick_data) begin
                        state_d = GNT_D;
                        // A data grant with no fetch waiting starts a fresh burst of one.
                        cnt_d   = IREQ ? (cnt_q + 4'd1) : 4'd1;
                        breq_d  = 1'b1;
                        ba_d    = DA;
                        bd_d    = DD_I;
                        bbe_d   = DBE;
                        bwr_d   = DWR;
                        bmrq_d  = DMRQ;
                        bst_d   = DST;
                    end else if (IREQ) begin
                        state_d = GNT_I;
                        cnt_d   = 4'd0;
                        breq_d  = 1'b1;
                        ba_d    = IA;
                        bd_d    = 32'd0;
                        bbe_d   = 4'hF;
                        bwr_d   = 1'b0;
                        bmrq_d  = 1'b1;
                        bst_d   = ST_IFETCH;
                    end
                end
                GNT_I, GNT_D: begin
                    if (BACK) begin
                        state_d = RESP;
                        breq_d  = 1'b0;
                        if (state_q == GNT_I) begin
                            id_d   = BD_I;
                            iack_d = 1'b1;
                        end else begin
                            dd_d   = BD_I;
                            dack_d = 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Requests are not sampled here; a held REQ is seen again in IDLE.
                    state_d = IDLE;
                    iack_d  = 1'b0;
                    dack_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, cleared immediately by RES.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            breq_q  <= 1'b0;
            iack_q  <= 1'b0;
            dack_q  <= 1'b0;
            id_q    <= 32'd0;
            dd_q    <= 32'd0;
            ba_q    <= 32'd0;
            bd_q    <= 32'd0;
            bbe_q   <= 4'd0;
            bwr_q   <= 1'b0;
            bmrq_q  <= 1'b0;
            bst_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            breq_q  <= breq_d;
            iack_q  <= iack_d;
            dack_q  <= dack_d;
            id_q    <= id_d;
            dd_q    <= dd_d;
            ba_q    <= ba_d;
            bd_q    <= bd_d;
            bbe_q   <= bbe_d;
            bwr_q   <= bwr_d;
            bmrq_q  <= bmrq_d;
            bst_q   <= bst_d;
        end
    end

    assign BREQ = breq_q;
    assign IACK = iack_q;
    assign DACK = dack_q;
    assign ID   = id_q;
    assign DD_O = dd_q;
    assign BA   = ba_q;
    assign BD_O = bd_q;
    assign BBE  = bbe_q;
    assign BWR  = bwr_q;
    assign BMRQ = bmrq_q;
    assign BST  = bst_q;

endmodule

// File: tb/tb_v810_bus_arb.sv
// Randomised bench for v810_bus_arb against a transaction-level reference:
// the model tracks who owns the bus, the pending acknowledge and the data
// grant streak, and predicts every output once per clock.
module tb_v810_bus_arb;

    localparam logic [1:0] ST_IFETCH   = 2'b11;
    localparam int         D_BURST_MAX = 4;

    logic        CLK = 1'b0;
    logic        RES, CE, IREQ, DREQ, DWR, DMRQ, BACK;
    logic [31:0] IA, DA, DD_I, BD_I;
    logic [3:0]  DBE;
    logic [1:0]  DST;
    logic        IACK, DACK, BREQ, BWR, BMRQ;
    logic [31:0] ID, DD_O, BA, BD_O;
    logic [3:0]  BBE;
    logic [1:0]  BST;

    v810_bus_arb #(.ST_IFETCH(ST_IFETCH), .D_BURST_MAX(D_BURST_MAX)) dut (
        .CLK(CLK), .RES(RES), .CE(CE),
        .IREQ(IREQ), .IA(IA), .IACK(IACK), .ID(ID),
        .DREQ(DREQ), .DA(DA), .DD_I(DD_I), .DBE(DBE), .DWR(DWR), .DMRQ(DMRQ),
        .DST(DST), .DACK(DACK), .DD_O(DD_O),
        .BREQ(BREQ), .BA(BA), .BD_O(BD_O), .BBE(BBE), .BWR(BWR), .BMRQ(BMRQ),
        .BST(BST), .BACK(BACK), .BD_I(BD_I)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference state: owner 0 = bus free, 1 = fetch cycle, 2 = data cycle.
    int          owner;
    int          streak;
    logic        m_breq, m_iack, m_dack, m_bwr, m_bmrq;
    logic [31:0] m_id, m_dd, m_ba, m_bd;
    logic [3:0]  m_bbe;
    logic [1:0]  m_bst;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; streak = 0;
        m_breq = 0; m_iack = 0; m_dack = 0; m_bwr = 0; m_bmrq = 0;
        m_id = 0; m_dd = 0; m_ba = 0; m_bd = 0; m_bbe = 0; m_bst = 0;
    endtask

    // Advance the reference by one clock edge using the inputs that edge saw.
    task automatic model_step();
        int pick;
        if (RES) begin
            model_reset();
            return;
        end
        if (!CE) return;
        if (m_iack || m_dack) begin
            m_iack = 0;
            m_dack = 0;
        end else if (owner != 0) begin
            if (BACK) begin
                m_breq = 0;
                n_txn++;
                if (owner == 1) begin
                    m_iack = 1; m_id = BD_I;
                    $display("txn %0d: fetch  addr %h data %h", n_txn, m_ba, BD_I);
                end else begin
                    m_dack = 1; m_dd = BD_I;
                    $display("txn %0d: data   addr %h wr %0d wdata %h rdata %h", n_txn, m_ba, m_bwr, m_bd, BD_I);
                end
                owner = 0;
            end
        end else begin
            pick = 0;
            if (IREQ && DREQ) pick = (streak < D_BURST_MAX) ? 2 : 1;
            else if (IREQ)    pick = 1;
            else if (DREQ)    pick = 2;
            if (pick == 2) begin
                streak = IREQ ? streak + 1 : 1;
                owner = 2; m_breq = 1;
                m_ba = DA; m_bd = DD_I; m_bbe = DBE; m_bwr = DWR; m_bmrq = DMRQ; m_bst = DST;
            end else if (pick == 1) begin
                streak = 0;
                owner = 1; m_breq = 1;
                m_ba = IA; m_bd = 0; m_bbe = 4'hF; m_bwr = 0; m_bmrq = 1; m_bst = ST_IFETCH;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_ctl"}, 64'({BREQ, IACK, DACK, BWR, BMRQ, BST, BBE}),
                  64'({m_breq, m_iack, m_dack, m_bwr, m_bmrq, m_bst, m_bbe}));
        check_val({tag, "_ba"}, 64'(BA), 64'(m_ba));
        check_val({tag, "_bd"}, 64'(BD_O), 64'(m_bd));
        check_val({tag, "_id"}, 64'(ID), 64'(m_id));
        check_val({tag, "_dd"}, 64'(DD_O), 64'(m_dd));
    endtask

    task automatic drive_random();
        CE = ($urandom_range(0, 3) != 0);
        if (!IREQ) begin
            if ($urandom_range(0, 2) == 0) begin IREQ = 1; IA = $urandom; end
        end else if (IACK) begin
            if ($urandom_range(0, 1) == 0) IA = $urandom; else IREQ = 0;
        end else if ($urandom_range(0, 15) == 0) begin
            IREQ = 0;
        end
        if (!DREQ) begin
            if ($urandom_range(0, 1) == 0) begin
                DREQ = 1; DA = $urandom; DD_I = $urandom; DBE = 4'($urandom);
                DWR = 1'($urandom); DMRQ = 1'($urandom); DST = 2'($urandom);
            end
        end else if (DACK) begin
            if ($urandom_range(0, 3) != 0) begin
                DA = $urandom; DD_I = $urandom; DBE = 4'($urandom);
                DWR = 1'($urandom); DMRQ = 1'($urandom); DST = 2'($urandom);
            end else DREQ = 0;
        end else if ($urandom_range(0, 15) == 0) begin
            DREQ = 0;
        end
        BACK = BREQ ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
        BD_I = $urandom;
    endtask

    task automatic do_cycle(input bit rnd);
        @(negedge CLK);
        model_step();
        compare_all("cyc");
        if (rnd) drive_random();
    endtask

    initial begin
        RES = 1; CE = 1; IREQ = 0; DREQ = 0; BACK = 0;
        IA = 0; DA = 0; DD_I = 0; BD_I = 0; DBE = 0; DWR = 0; DMRQ = 0; DST = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        compare_all("reset");
        RES = 0;
        repeat (4) do_cycle(0);

        repeat (2500) do_cycle(1);

        // Quiesce, then start a data cycle and reset it while BREQ is high.
        IREQ = 0; DREQ = 0; BACK = 0; CE = 1;
        repeat (12) do_cycle(0);
        DREQ = 1; DA = 32'h0500_0004; DD_I = 32'hCAFE_BABE; DBE = 4'h3;
        DWR = 1; DMRQ = 1; DST = 2'b10;
        do_cycle(0);
        check_val("grant_breq", 64'(BREQ), 64'(1));
        RES = 1;
        #1;
        model_reset();
        compare_all("async_rst");
        DREQ = 0;
        @(negedge CLK);
        RES = 0;
        repeat (4) do_cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/v810_bus_arb.md
Name: v810_bus_arb

Overview:
- Arbitrates between the execution unit's instruction-fetch port and its data-access port.
- Presents a single serialized bus-cycle request to the external bus-cycle sequencer inside the memory unit.
- Owns grant priority, starvation control, request/response muxing and the status code driven for each cycle.
- Sits between v810_exec and the bus-cycle logic of v810_mem.

Parameters:
- ST_IFETCH, 2'b11: ST code driven on the bus for instruction-fetch cycles.
- D_BURST_MAX, 4: maximum consecutive data grants while a fetch is pending before the fetch is forced (1..15).

Ports:
- CLK  in  1  system clock
- RES  in  1  asynchronous reset, active-high
- CE  in  1  global clock enable; all state advances only when CE=1
- IREQ  in  1  fetch request, level
- IA  in  32  fetch address
- IACK  out  1  fetch complete, 1-cycle pulse
- ID  out  32  fetch data, valid with IACK
- DREQ  in  1  data request, level
- DA  in  32  data address
- DD_I  in  32  store data
- DBE  in  4  byte enables
- DWR  in  1  1=write
- DMRQ  in  1  1=memory space, 0=I/O
- DST  in  2  data-cycle status code
- DACK  out  1  data complete, 1-cycle pulse
- DD_O  out  32  load data, valid with DACK
- BREQ  out  1  bus-cycle request to sequencer
- BA  out  32  cycle address
- BD_O  out  32  cycle write data
- BBE  out  4  cycle byte enables
- BWR  out  1  cycle direction
- BMRQ  out  1  cycle space
- BST  out  2  cycle status
- BACK  in  1  sequencer done, 1-cycle pulse
- BD_I  in  32  sequencer read data, valid with BACK

Behaviour:
- Reset values (asynchronous, immediate on RES=1): state IDLE, burst counter 0, and all outputs 0 (BREQ, IACK, DACK, ID, DD_O, BA, BD_O, BBE, BWR, BMRQ, BST).
- States: IDLE, GNT_I, GNT_D, RESP. All transitions are qualified by CE; with CE=0 every register holds.

IDLE arbitration:
- Only DREQ=1: go to GNT_D.
- Only IREQ=1: go to GNT_I.
- Both, with counter < D_BURST_MAX: go to GNT_D and increment the counter.
- Both, with counter = D_BURST_MAX: go to GNT_I.
- Counter reset: any GNT_I entry clears the counter. A GNT_D entry while IREQ=0 also clears it, then the counter counts that grant as 1.
- Neither request: stay in IDLE.

Grant entry (registered):
- Latch BA/BD_O/BBE/BWR/BMRQ/BST from the winning port and assert BREQ=1 in the next cycle.
- Fetch fields: BA=IA, BWR=0, BMRQ=1, BBE=4'hF, BST=ST_IFETCH, BD_O=0.
- Data fields: straight copy of DA/DD_I/DBE/DWR/DMRQ/DST.
- Latency from REQ to BREQ: 1 enabled cycle.

GNT_x:
- BREQ and the latched fields stay constant until BACK=1.
- On BACK: BREQ goes to 0 in the next cycle, BD_I is latched into ID (GNT_I) or DD_O (GNT_D), the matching ACK=1 for exactly one cycle, and the state goes to RESP.
- Other fields hold their last value (don't-care to the sequencer).

RESP:
- Lasts 1 cycle, with ACK asserted; IREQ and DREQ are not sampled. Next state is IDLE.
- A requester that keeps REQ high after seeing ACK is issuing a new request, arbitrated in IDLE.
- Minimum spacing between grants: BACK, then RESP, then IDLE, then grant.

Requester rules:
- REQ with its fields must stay stable from assertion until ACK.
- Dropping REQ before a grant is legal and has no effect.
- Dropping REQ after a grant is ignored: the cycle completes and ACK still pulses.

Boundaries:
- BACK outside GNT_x: ignored, no ACK.
- BACK on the same cycle the grant is being entered: ignored, because BREQ is not yet visible.
- ID and DD_O hold their value until the next completion on their port.
- Reset mid-cycle: BREQ drops at once and no ACK is produced; requesters re-issue after reset.
- D_BURST_MAX=0 is illegal.

Test Plan:
- Reset: RES=1 while in GNT_D with BREQ=1 -> BREQ=0 and all outputs 0 in the same cycle; after release with no requests the state stays IDLE.
- Single fetch: IREQ=1, IA=0xFFFFFFF0; BACK on the 3rd cycle with BD_I=0x12345678 -> BREQ=1 one cycle after IREQ; BA=0xFFFFFFF0, BST=2'b11, BWR=0, BBE=4'hF; IACK one-cycle pulse with ID=0x12345678; DACK stays 0.
- Data store: DREQ=1, DA=0x05000004, DD_I=0xCAFEBABE, DBE=4'h3, DWR=1, DMRQ=1, DST=2'b10 -> bus fields copied exactly; DACK pulse one cycle after BACK.
- Simultaneous requests: IREQ=1 and DREQ=1 asserted together, both held continuously with immediate BACK on every grant, D_BURST_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; the fetch is never starved.
- CE gating: toggle CE=0 on alternate cycles during a data cycle -> state and outputs freeze while CE=0; a BACK pulse presented only while CE=0 is ignored; ACK appears only after a CE=1 BACK.
- Protocol edges: DREQ dropped after grant -> cycle completes and DACK still pulses. Spurious BACK in IDLE -> no ACK. REQ held high through ACK -> second grant 2 cycles after ACK with the new fields.
